cpu_trace_checker: RTL and testbench

Streaming, one-character-per-cycle recogniser for CPU trace lines. It classifies each line as a register write or a memory write, extracts the numeric fields, and optionally checks them for semantic errors. It sits between the simulator's character output and the trace comparator. It is the parametrised successor to the fixed-width format checker: digit counts and hex width are configurable, decoded field values are exported, and accepted lines are counted.

---
 rtl/cpu_trace_pkg.sv | 51 +++++
 rtl/cpu_trace_checker_char_class.sv | 32 +++
 rtl/cpu_trace_checker.sv | 255 +++++++++++++++++++++++++
 tb/tb_cpu_trace_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace line recogniser.
// Holds the FSM state enum, format codes, error bit indices and ASCII constants.
package cpu_trace_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CARET,
        ST_TIME,
        ST_AT,
        ST_PC,
        ST_SEP,
        ST_REGNUM,
        ST_MEMADDR,
        ST_PRE_LT,
        ST_LT,
        ST_POST_EQ,
        ST_DATA
    } state_e;

    typedef enum logic [1:0] {
        FMT_NONE = 2'b00,
        FMT_REG  = 2'b01,
        FMT_MEM  = 2'b10
    } fmt_e;

    localparam int ERR_PC_RANGE   = 0;
    localparam int ERR_PC_ALIGN   = 1;
    localparam int ERR_ADDR_ALIGN = 2;
    localparam int ERR_REG_RANGE  = 3;

    localparam logic [7:0] CH_CARET  = 8'h5e;  // ^
    localparam logic [7:0] CH_AT     = 8'h40;  // @
    localparam logic [7:0] CH_COLON  = 8'h3a;  // :
    localparam logic [7:0] CH_DOLLAR = 8'h24;  // $
    localparam logic [7:0] CH_STAR   = 8'h2a;  // *
    localparam logic [7:0] CH_LT     = 8'h3c;  // <
    localparam logic [7:0] CH_EQ     = 8'h3d;  // =
    localparam logic [7:0] CH_HASH   = 8'h23;  // #
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;
    localparam logic [7:0] CH_LC_A   = 8'h61;
    localparam logic [7:0] CH_LC_F   = 8'h66;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cpu_trace_checker_char_class.sv
// Combinational character classifier: decimal digit, lowercase hex digit, nibble value.
module trace_char_class
    import cpu_trace_pkg::*;
(
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);

    logic is_lc_hex;
    logic [7:0] dec_off;
    logic [7:0] hex_off;

    assign is_dec    = (char >= CH_0) && (char <= CH_9);
    assign is_lc_hex = (char >= CH_LC_A) && (char <= CH_LC_F);
    assign is_hex    = is_dec || is_lc_hex;

    assign dec_off = char - CH_0;
    assign hex_off = char - CH_LC_A + 8'd10;

    always_comb begin
        // NOTE: default first so every path assigns nibble; a missing branch would infer a latch.
        nibble = 4'h0;
        if (is_dec) begin
            nibble = dec_off[3:0];
        end else if (is_lc_hex) begin
            nibble = hex_off[3:0];
        end
    end

endmodule

// File: rtl/cpu_trace_checker.sv
// Streaming trace-line recogniser: decodes register/memory write lines and counts accepted ones.
// Define CPU_TRACE_FIELD_CHECK_EN to build the PC/address/register semantic checks on error_code.
module cpu_trace_checker
    import cpu_trace_pkg::*;
#(
    parameter int                      TIME_DIGITS = 4,
    parameter int                      REG_DIGITS  = 4,
    parameter int                      HEX_DIGITS  = 8,
    parameter int                      TIME_W      = 16,
    parameter logic [4*HEX_DIGITS-1:0] PC_MIN      = 'h0000_3000,
    parameter logic [4*HEX_DIGITS-1:0] PC_MAX      = 'h0000_6ffc
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                char,
    output logic [1:0]                format_type,
    output logic [TIME_W-1:0]         line_time,
    output logic [4*HEX_DIGITS-1:0]   line_pc,
    output logic [4*HEX_DIGITS-1:0]   line_addr,
    output logic [4*HEX_DIGITS-1:0]   line_data,
    output logic [3:0]                error_code,
    output logic [15:0]               line_cnt
);

    localparam int HW      = 4 * HEX_DIGITS;
    // Saturation point covers the widest field so every overflow is still visible.
    localparam int CNT_SAT = max3(TIME_DIGITS, REG_DIGITS, HEX_DIGITS) + 1;
    localparam int CNT_W   = $clog2(CNT_SAT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CNT_SAT);
    localparam logic [CNT_W-1:0] TIME_LIM = CNT_W'(TIME_DIGITS);
    localparam logic [CNT_W-1:0] REG_LIM  = CNT_W'(REG_DIGITS);
    localparam logic [CNT_W-1:0] HEX_LIM  = CNT_W'(HEX_DIGITS);

    logic       is_dec;
    logic       is_hex;
    logic [3:0] nibble;

    trace_char_class u_char_class (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nibble (nibble)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [HW-1:0]      pc_q, pc_d;
    logic [HW-1:0]      addr_q, addr_d;
    logic [7:0]         reg_q, reg_d;
    logic [HW-1:0]      data_q, data_d;
    fmt_e               type_q, type_d;
    logic               accept;

    fmt_e               fmt_q, fmt_d;
    logic [TIME_W-1:0]  line_time_q, line_time_d;
    logic [HW-1:0]      line_pc_q, line_pc_d;
    logic [HW-1:0]      line_addr_q, line_addr_d;
    logic [HW-1:0]      line_data_q, line_data_d;
    logic [3:0]         err_q, err_d;
    logic [15:0]        cnt_lines_q, cnt_lines_d;
    logic [3:0]         err_flags;

    logic [CNT_W-1:0]   cnt_inc;
    logic [TIME_W-1:0]  time_mac;
    logic [11:0]        reg_wide;
    logic [7:0]         reg_sat;
    logic               is_space;

    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign time_mac = time_q * TIME_W'(10) + TIME_W'(nibble);
    assign reg_wide = 12'(reg_q) * 12'd10 + 12'(nibble);
    assign reg_sat  = (reg_wide > 12'd255) ? 8'hff : reg_wide[7:0];
    assign is_space = (char == CH_SPACE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        time_d  = time_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        reg_d   = reg_q;
        data_d  = data_q;
        type_d  = type_q;
        accept  = 1'b0;

        if (char == CH_CARET) begin
            state_d = ST_CARET;
            cnt_d   = '0;
            time_d  = '0;
            pc_d    = '0;
            addr_d  = '0;
            reg_d   = '0;
            data_d  = '0;
            type_d  = FMT_NONE;
        end else begin
            // Anything not explicitly legal below abandons the line.
            state_d = ST_IDLE;
            case (state_q)
                ST_CARET: if (is_dec) begin
                    state_d = ST_TIME;
                    cnt_d   = cnt_inc;
                    time_d  = time_mac;
                end
                ST_TIME: if (is_dec && cnt_q < TIME_LIM) begin
                    state_d = ST_TIME;
                    cnt_d   = cnt_inc;
                    time_d  = time_mac;
                end else if (char == CH_AT) begin
                    state_d = ST_AT;
                    cnt_d   = '0;
                end
                ST_AT, ST_PC: if (is_hex && cnt_q < HEX_LIM) begin
                    state_d = ST_PC;
                    cnt_d   = cnt_inc;
                    pc_d    = {pc_q[HW-5:0], nibble};
                end else if (state_q == ST_PC && char == CH_COLON && cnt_q == HEX_LIM) begin
                    state_d = ST_SEP;
                    cnt_d   = '0;
                end
                ST_SEP: if (is_space) begin
                    state_d = ST_SEP;
                end else if (char == CH_DOLLAR) begin
                    state_d = ST_REGNUM;
                    type_d  = FMT_REG;
                    cnt_d   = '0;
                end else if (char == CH_STAR) begin
                    state_d = ST_MEMADDR;
                    type_d  = FMT_MEM;
                    cnt_d   = '0;
                end
                ST_REGNUM: if (is_dec && cnt_q < REG_LIM) begin
                    state_d = ST_REGNUM;
                    cnt_d   = cnt_inc;
                    reg_d   = reg_sat;
                end else if ((is_space || char == CH_LT) && cnt_q != '0) begin
                    state_d = is_space ? ST_PRE_LT : ST_LT;
                    cnt_d   = '0;
                end
                ST_MEMADDR: if (is_hex && cnt_q < HEX_LIM) begin
                    state_d = ST_MEMADDR;
                    cnt_d   = cnt_inc;
                    addr_d  = {addr_q[HW-5:0], nibble};
                end else if ((is_space || char == CH_LT) && cnt_q == HEX_LIM) begin
                    state_d = is_space ? ST_PRE_LT : ST_LT;
                    cnt_d   = '0;
                end
                ST_PRE_LT: if (is_space) begin
                    state_d = ST_PRE_LT;
                end else if (char == CH_LT) begin
                    state_d = ST_LT;
                end
                ST_LT: if (char == CH_EQ) begin
                    state_d = ST_POST_EQ;
                    cnt_d   = '0;
                end
                ST_POST_EQ, ST_DATA: if (is_space && state_q == ST_POST_EQ) begin
                    state_d = ST_POST_EQ;
                end else if (is_hex && cnt_q < HEX_LIM) begin
                    state_d = ST_DATA;
                    cnt_d   = cnt_inc;
                    data_d  = {data_q[HW-5:0], nibble};
                end else if (state_q == ST_DATA && char == CH_HASH && cnt_q == HEX_LIM) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef CPU_TRACE_FIELD_CHECK_EN
    always_comb begin
        err_flags                 = 4'b0000;
        err_flags[ERR_PC_RANGE]   = (pc_q < PC_MIN) || (pc_q > PC_MAX);
        err_flags[ERR_PC_ALIGN]   = (pc_q[1:0] != 2'b00);
        err_flags[ERR_ADDR_ALIGN] = (type_q == FMT_MEM) && (addr_q[1:0] != 2'b00);
        err_flags[ERR_REG_RANGE]  = (type_q == FMT_REG) && (reg_q > 8'd31);
    end
`else
    assign err_flags = 4'b0000;
`endif

    always_comb begin
        fmt_d       = FMT_NONE;
        line_time_d = line_time_q;
        line_pc_d   = line_pc_q;
        line_addr_d = line_addr_q;
        line_data_d = line_data_q;
        err_d       = err_q;
        cnt_lines_d = cnt_lines_q;
        if (accept) begin
            fmt_d       = type_q;
            line_time_d = time_q;
            line_pc_d   = pc_q;
            line_addr_d = (type_q == FMT_REG) ? HW'(reg_q) : addr_q;
            line_data_d = data_q;
            err_d       = err_flags;
            cnt_lines_d = cnt_lines_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            time_q  <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            type_q  <= FMT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            time_q  <= time_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            type_q  <= type_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fmt_q       <= FMT_NONE;
            line_time_q <= '0;
            line_pc_q   <= '0;
            line_addr_q <= '0;
            line_data_q <= '0;
            err_q       <= '0;
            cnt_lines_q <= '0;
        end else begin
            fmt_q       <= fmt_d;
            line_time_q <= line_time_d;
            line_pc_q   <= line_pc_d;
            line_addr_q <= line_addr_d;
            line_data_q <= line_data_d;
            err_q       <= err_d;
            cnt_lines_q <= cnt_lines_d;
        end
    end

    assign format_type = fmt_q;
    assign line_time   = line_time_q;
    assign line_pc     = line_pc_q;
    assign line_addr   = line_addr_q;
    assign line_data   = line_data_q;
    assign error_code  = err_q;
    assign line_cnt    = cnt_lines_q;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Scoreboard bench for cpu_trace_checker: stimulus pushes expected lines, a monitor pops on each pulse.
module tb_cpu_trace_checker;

    logic        clk;
    logic        reset;
    logic [7:0]  char;
    logic [1:0]  format_type;
    logic [15:0] line_time;
    logic [31:0] line_pc;
    logic [31:0] line_addr;
    logic [31:0] line_data;
    logic [3:0]  error_code;
    logic [15:0] line_cnt;

    cpu_trace_checker dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .format_type (format_type),
        .line_time   (line_time),
        .line_pc     (line_pc),
        .line_addr   (line_addr),
        .line_data   (line_data),
        .error_code  (error_code),
        .line_cnt    (line_cnt)
    );

    typedef struct {
        logic [1:0]  fmt;
        logic [15:0] t;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  err;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_cnt;
    int          checks;
    int          failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // err_on is the flag set the semantic checks should report when they are built.
    task automatic expect_line(input logic [1:0] f, input logic [15:0] t, input logic [31:0] pc,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] err_on);
        exp_t e;
        exp_cnt = exp_cnt + 16'd1;
        e.fmt  = f;
        e.t    = t;
        e.pc   = pc;
        e.addr = addr;
        e.data = data;
`ifdef CPU_TRACE_FIELD_CHECK_EN
        e.err  = err_on;
`else
        e.err  = 4'b0000;
`endif
        e.cnt  = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            char = s[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        char = 8'h00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected pulses missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_fmt"},  64'(format_type), 64'd0);
        check({tag, "_time"}, 64'(line_time),   64'd0);
        check({tag, "_pc"},   64'(line_pc),     64'd0);
        check({tag, "_addr"}, 64'(line_addr),   64'd0);
        check({tag, "_data"}, 64'(line_data),   64'd0);
        check({tag, "_err"},  64'(error_code),  64'd0);
        check({tag, "_cnt"},  64'(line_cnt),    64'd0);
    endtask

    // Monitor: every non-zero format_type must match the next queued expectation and last one cycle.
    initial begin
        bit prev_pulse;
        exp_t e;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pulse = 1'b0;
            end else begin
                if (prev_pulse) check("pulse_width", 64'(format_type), 64'd0);
                prev_pulse = (format_type != 2'b00);
                if (format_type != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse: got format_type %b, expected 00", format_type);
                    end else begin
                        e = exp_q.pop_front();
                        check("fmt",  64'(format_type), 64'(e.fmt));
                        check("time", 64'(line_time),   64'(e.t));
                        check("pc",   64'(line_pc),     64'(e.pc));
                        check("addr", 64'(line_addr),   64'(e.addr));
                        check("data", 64'(line_data),   64'(e.data));
                        check("err",  64'(error_code),  64'(e.err));
                        check("cnt",  64'(line_cnt),    64'(e.cnt));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 16'd0;
        reset    = 1'b1;
        char     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        expect_line(2'b01, 16'd10, 32'h0000_3000, 32'd1, 32'h0000_000a, 4'b0000);
        send_str("^10@00003000: $1 <= 0000000a#");
        idle(3);

        // Back-to-back: the second caret lands on the pulse cycle.
        expect_line(2'b10, 16'd123, 32'h0000_3004, 32'h0000_0010, 32'hdead_beef, 4'b0000);
        send_str("^123@00003004:*00000010<=deadbeef#");
        expect_line(2'b01, 16'd7, 32'h0000_3008, 32'd5, 32'h0000_0001, 4'b0000);
        send_str("^7@00003008:$5<=00000001#");
        idle(3);
        drain("drain_b2b");

        send_str("^12345@00003000:$1<=00000000#");
        idle(1);
        send_str("^1@0000300:$1<=00000000#");
        idle(1);
        send_str("^1@0000300A:$1<=00000000#");
        idle(1);
        send_str("^1@00003000:$1< =00000000#");
        idle(1);
        send_str("^1@00003000:$ 1<=00000000#");
        idle(1);
        send_str("^1@00003000:*0000001<=00000000#");
        idle(3);
        check("reject_cnt", 64'(line_cnt), 64'(exp_cnt));

        expect_line(2'b01, 16'd1, 32'h0000_2ffe, 32'd32, 32'h0000_0000, 4'b1011);
        send_str("^1@00002ffe: $32 <= 00000000#");
        idle(2);

        expect_line(2'b01, 16'd2, 32'h0000_3000, 32'd0, 32'h0000_0000, 4'b0000);
        send_str("^1@000^2@00003000:$0<=00000000#");
        idle(2);

        expect_line(2'b10, 16'd9999, 32'h0000_7000, 32'h0000_0006, 32'hffff_ffff, 4'b0101);
        send_str("^9999@00007000:*00000006 <=  ffffffff#");
        idle(2);

        // Register number saturates at 255; PC at the upper legal bound.
        expect_line(2'b01, 16'd0, 32'h0000_6ffc, 32'd255, 32'h1234_5678, 4'b1000);
        send_str("^0@00006ffc:$9999<=12345678#");
        idle(3);
        drain("drain_fields");

        send_str("^5@00003000:$1<=0000");
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midreset");
        exp_cnt = 16'd0;
        char = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_line(2'b01, 16'd42, 32'h0000_3010, 32'd3, 32'h0bad_f00d, 4'b0000);
        send_str("^42@00003010:$3<=0badf00d#");
        idle(3);
        drain("drain_after_reset");
        check("final_cnt", 64'(line_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
